clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_multi_if.sv | 14 +
 rtl/clk_div_multi.sv | 63 ++++++
 tb/tb_clk_div_multi.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: control and divided-clock bundle for clk_div_multi
interface clk_div_multi_if #(
  parameter int NUM_CH   = 4,
  parameter int RATIO_WD = 8
);
  logic [NUM_CH-1:0]          i_clk_en;
  logic [NUM_CH*RATIO_WD-1:0] i_div_ratio;
  logic                       i_sync;
  logic [NUM_CH-1:0]          o_div_clk;
  logic [NUM_CH-1:0]          o_tick;
  logic [NUM_CH-1:0]          o_active;
  modport master (output i_clk_en, i_div_ratio, i_sync, input o_div_clk, o_tick, o_active);
  modport slave  (input i_clk_en, i_div_ratio, i_sync, output o_div_clk, o_tick, o_active);
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: independent glitch-free integer clock dividers with shared in-phase sync
module clk_div_multi #(
  parameter int NUM_CH   = 4,
  parameter int RATIO_WD = 8
) (
  input  logic            i_ref_clk,
  input  logic            i_rst,
  clk_div_multi_if.slave  bus
);
  typedef enum logic {BYPASS, RUN} state_t;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t              state, state_n;
    logic [RATIO_WD-1:0] r, r_n, cnt, cnt_n, ratio_in;
    logic [RATIO_WD:0]   h;
    logic                div, div_n, tick, tick_n, bnd, ok, en;
    assign ratio_in = bus.i_div_ratio[c*RATIO_WD +: RATIO_WD];
    assign en       = bus.i_clk_en[c];
    assign ok       = ratio_in >= RATIO_WD'(2);
    assign h        = ({1'b0, r} + 1'b1) >> 1;
    assign bnd      = (cnt == r - 1'b1) || bus.i_sync;
    always_comb begin
      state_n = state;
      r_n     = r;
      cnt_n   = '0;
      div_n   = 1'b0;
      tick_n  = 1'b0;
      if (state == BYPASS) begin
        r_n     = ratio_in;
        state_n = en && ok ? RUN : BYPASS;
        div_n   = en && ok;
        tick_n  = en && ok;
      end else if (!en) begin
        state_n = BYPASS;
      end else if (bnd) begin
        r_n     = ratio_in;
        state_n = ok ? RUN : BYPASS;
        div_n   = ok;
        tick_n  = ok;
      end else begin
        cnt_n = cnt + 1'b1;
        div_n = ({1'b0, cnt} + 1'b1) < h;
      end
    end
    always_ff @(posedge i_ref_clk) begin
      if (i_rst) begin
        state <= BYPASS;
        r     <= '0;
        cnt   <= '0;
        div   <= 1'b0;
        tick  <= 1'b0;
      end else begin
        state <= state_n;
        r     <= r_n;
        cnt   <= cnt_n;
        div   <= div_n;
        tick  <= tick_n;
      end
    end
    assign bus.o_div_clk[c] = state == RUN ? div : i_ref_clk;
    assign bus.o_tick[c]    = tick;
    assign bus.o_active[c]  = state == RUN;
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed scoreboard bench for clk_div_multi
module tb_clk_div_multi;
  localparam int NC = 4;
  localparam int RW = 8;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  typedef struct {
    string tag;
    int    ch;
    logic  d;
    logic  t;
    logic  a;
  } exp_t;
  exp_t q[$];
  clk_div_multi_if #(.NUM_CH(NC), .RATIO_WD(RW)) bus ();
  clk_div_multi #(.NUM_CH(NC), .RATIO_WD(RW)) dut (
    .i_ref_clk(clk),
    .i_rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic got, input logic want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, want);
    end
  endtask
  task automatic exp(input string tag, input int ch, input logic d, input logic t, input logic a);
    exp_t e;
    e.tag = tag;
    e.ch  = ch;
    e.d   = d;
    e.t   = t;
    e.a   = a;
    q.push_back(e);
  endtask
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".div"}, bus.o_div_clk[e.ch], e.d);
      chk({e.tag, ".tick"}, bus.o_tick[e.ch], e.t);
      chk({e.tag, ".act"}, bus.o_active[e.ch], e.a);
    end
  endtask
  task automatic neg_chk(input string tag, input int ch);
    @(negedge clk);
    #1;
    chk({tag, ".neg_div"}, bus.o_div_clk[ch], 1'b0);
  endtask
  task automatic run_pat(input string tag, input int ch, input string d, input string t);
    for (int i = 0; i < d.len(); i++) begin
      exp(tag, ch, d.getc(i) == 8'h31, t.getc(i) == 8'h31, 1'b1);
      cyc();
    end
  endtask
  task automatic set_ratio(input int ch, input logic [RW-1:0] r);
    bus.i_div_ratio[ch*RW +: RW] = r;
  endtask
  task automatic all_bypass(input string tag);
    for (int c = 0; c < NC; c++) exp(tag, c, 1'b1, 1'b0, 1'b0);
  endtask
  initial begin
    rst = 1'b1;
    bus.i_clk_en = '0;
    bus.i_div_ratio = '0;
    bus.i_sync = 1'b0;
    all_bypass("reset");
    cyc();
    neg_chk("reset", 0);
    rst = 1'b0;
    set_ratio(0, 8'd4);
    bus.i_clk_en = 4'b0001;
    run_pat("r4", 0, "110011001100", "100010001000");
    run_pat("r4b", 0, "11", "10");
    set_ratio(0, 8'd6);
    run_pat("r4to6_cur", 0, "00", "00");
    run_pat("r6", 0, "111000111000", "100000100000");
    bus.i_clk_en = 4'b0000;
    exp("dis", 0, 1'b1, 1'b0, 1'b0);
    cyc();
    neg_chk("dis", 0);
    set_ratio(1, 8'd5);
    bus.i_clk_en = 4'b0010;
    run_pat("r5", 1, "1110011100", "1000010000");
    set_ratio(2, 8'd2);
    bus.i_clk_en = 4'b0100;
    run_pat("r2", 2, "101010", "101010");
    set_ratio(3, 8'd255);
    bus.i_clk_en = 4'b1000;
    for (int i = 0; i < 256; i++) begin
      exp("r255", 3, (i % 255) < 128, (i % 255) == 0, 1'b1);
      cyc();
    end
    bus.i_clk_en = 4'b0000;
    all_bypass("off");
    cyc();
    set_ratio(0, 8'd4);
    set_ratio(1, 8'd6);
    set_ratio(2, 8'd3);
    bus.i_clk_en = 4'b0011;
    exp("sy0", 0, 1'b1, 1'b1, 1'b1);
    exp("sy1", 1, 1'b1, 1'b1, 1'b1);
    cyc();
    exp("sy0", 0, 1'b1, 1'b0, 1'b1);
    exp("sy1", 1, 1'b1, 1'b0, 1'b1);
    cyc();
    exp("sy0", 0, 1'b0, 1'b0, 1'b1);
    exp("sy1", 1, 1'b1, 1'b0, 1'b1);
    cyc();
    bus.i_sync = 1'b1;
    exp("sync0", 0, 1'b1, 1'b1, 1'b1);
    exp("sync1", 1, 1'b1, 1'b1, 1'b1);
    exp("sync_byp", 2, 1'b1, 1'b0, 1'b0);
    cyc();
    bus.i_sync = 1'b0;
    exp("post0", 0, 1'b1, 1'b0, 1'b1);
    exp("post1", 1, 1'b1, 1'b0, 1'b1);
    cyc();
    exp("post0", 0, 1'b0, 1'b0, 1'b1);
    exp("post1", 1, 1'b1, 1'b0, 1'b1);
    cyc();
    bus.i_sync = 1'b1;
    bus.i_clk_en = 4'b0001;
    exp("syncdis0", 0, 1'b1, 1'b1, 1'b1);
    exp("syncdis1", 1, 1'b1, 1'b0, 1'b0);
    cyc();
    bus.i_sync = 1'b0;
    set_ratio(2, 8'd1);
    bus.i_clk_en = 4'b0100;
    exp("r1", 2, 1'b1, 1'b0, 1'b0);
    cyc();
    neg_chk("r1", 2);
    set_ratio(2, 8'd0);
    exp("r0", 2, 1'b1, 1'b0, 1'b0);
    cyc();
    neg_chk("r0", 2);
    set_ratio(2, 8'd3);
    run_pat("r3", 2, "1", "1");
    set_ratio(2, 8'd1);
    run_pat("r3to1", 2, "10", "00");
    exp("r3to1_byp", 2, 1'b1, 1'b0, 1'b0);
    cyc();
    neg_chk("r3to1_byp", 2);
    for (int c = 0; c < NC; c++) set_ratio(c, 8'd4);
    bus.i_clk_en = 4'b1111;
    run_pat("pre_rst", 0, "110", "100");
    rst = 1'b1;
    all_bypass("mid_rst");
    cyc();
    neg_chk("mid_rst", 0);
    rst = 1'b0;
    for (int c = 0; c < NC; c++) exp("rel", c, 1'b1, 1'b1, 1'b1);
    cyc();
    run_pat("rel2", 0, "100", "000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
